// File: rtl/avb_mm_block_copier.sv
// Avalon-MM master that copies or fills blocks of words in a 1-cycle-latency on-chip memory.
// Copy costs 3 cycles per word (RD/WAIT/WR), fill 1 cycle per word; a running XOR of written words is kept.
module avb_mm_block_copier #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [ADDR_W:0]     cmd_len,
  input  logic [DATA_W-1:0]   cmd_fill,
  input  logic                cmd_abort,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FILL, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                active;

  assign active = (state_q == S_RD) || (state_q == S_WAIT) ||
                  (state_q == S_WR) || (state_q == S_FILL);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    fill_d     = fill_q;
    data_d     = data_q;
    checksum_d = checksum_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (cmd_valid) begin
          src_d      = cmd_src;
          dst_d      = cmd_dst;
          rem_d      = cmd_len;
          fill_d     = cmd_fill;
          checksum_d = '0;
          if (cmd_len == '0)  state_d = S_DONE;
          else if (cmd_mode)  state_d = S_FILL;
          else                state_d = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        data_d  = avm_readdata;
        state_d = S_WR;
      end
      S_WR: begin
        checksum_d = checksum_q ^ data_q;
        src_d      = src_q + ADDR_W'(1);
        dst_d      = dst_q + ADDR_W'(1);
        rem_d      = rem_q - (ADDR_W+1)'(1);
        state_d    = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_RD;
      end
      S_FILL: begin
        checksum_d = checksum_q ^ fill_q;
        dst_d      = dst_q + ADDR_W'(1);
        rem_d      = rem_q - (ADDR_W+1)'(1);
        state_d    = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase

    // The write driven in the abort cycle still lands, so its checksum update is kept.
    if (cmd_abort && active) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    avm_address    = '0;
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    case (state_q)
      S_RD: begin
        avm_address    = src_q;
        avm_chipselect = 1'b1;
      end
      S_WAIT: avm_address = src_q;
      S_WR: begin
        avm_address    = dst_q;
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_writedata  = data_q;
      end
      S_FILL: begin
        avm_address    = dst_q;
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_writedata  = fill_q;
      end
      default: ;
    endcase
  end

  assign cmd_ready      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy           = active;
  assign done           = (state_q == S_DONE);
  assign checksum       = checksum_q;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;

endmodule

// File: tb/tb_avb_mm_block_copier.sv
// Bench for avb_mm_block_copier: memory model on the bus, array-level reference of copy/fill results.
module tb_avb_mm_block_copier;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_mode = 1'b0;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [AW:0]   cmd_len = '0;
  logic [DW-1:0] cmd_fill = '0;
  logic          cmd_abort = 1'b0;
  logic          busy, done;
  logic [DW-1:0] checksum;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write;
  logic [DW/8-1:0] avm_byteenable;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          avm_clken;

  always #5 clk = ~clk;

  avb_mm_block_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .cmd_abort(cmd_abort), .busy(busy), .done(done), .checksum(checksum),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_clken(avm_clken)
  );

  // On-chip memory: single port, registered read, writes only with full byte enables.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdata_q;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (avm_chipselect && avm_write && (&avm_byteenable)) mem[avm_address] <= avm_writedata;
    rdata_q <= mem[avm_address];
  end
  assign avm_readdata = rdata_q;

  int cyc = 0;
  int done_cnt = 0;
  int cs_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (avm_chipselect === 1'b1) cs_cnt <= cs_cnt + 1;
  end

  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] ref_ck;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_dat = v;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = v;
  endtask

  // Reference: ascending word-by-word transfer, addresses wrap modulo N.
  task automatic model(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input int nwords, input logic [DW-1:0] fill);
    logic [AW-1:0] s, d;
    logic [DW-1:0] v;
    s = src; d = dst; ref_ck = '0;
    for (int k = 0; k < nwords; k++) begin
      v = mode ? fill : ref_mem[s];
      ref_mem[d] = v;
      ref_ck ^= v;
      s = s + 1'b1; d = d + 1'b1;
    end
  endtask

  task automatic mem_cmp(input string tag);
    int nbad;
    nbad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk({tag, "_mem"}, 64'(nbad), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    chk({tag, "_cs"}, 64'(avm_chipselect), 64'd0);
    chk({tag, "_wr"}, 64'(avm_write), 64'd0);
    chk({tag, "_addr"}, 64'(avm_address), 64'd0);
    chk({tag, "_wdata"}, 64'(avm_writedata), 64'd0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_be"}, 64'(avm_byteenable), 64'hF);
    chk({tag, "_clken"}, 64'(avm_clken), 64'd1);
  endtask

  task automatic issue(input string tag, input logic mode, input logic [AW-1:0] src,
                       input logic [AW-1:0] dst, input int len, input logic [DW-1:0] fill,
                       output int c0);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 100) begin tick(); w++; end
    if (cmd_ready !== 1'b1) chk({tag, "_ready_wait"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_src = src; cmd_dst = dst;
    cmd_len = (AW+1)'(len); cmd_fill = fill;
    tick();
    c0 = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic mode, input logic [AW-1:0] src,
                     input logic [AW-1:0] dst, input int len, input logic [DW-1:0] fill);
    int c0, d0, lat, exp_lat, busy_bad, i;
    d0 = done_cnt;
    model(mode, src, dst, len, fill);
    issue(tag, mode, src, dst, len, fill, c0);
    exp_lat = (len == 0) ? 0 : (mode ? len : 3 * len);
    busy_bad = 0;
    i = 0;
    while (done !== 1'b1 && i < 3 * len + 10) begin
      if (busy !== 1'b1) busy_bad++;
      tick(); i++;
    end
    lat = (done === 1'b1) ? cyc - c0 : -1;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_active"}, 64'(busy_bad), 64'd0);
    chk({tag, "_checksum"}, 64'(checksum), 64'(ref_ck));
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    mem_cmp(tag);
  endtask

  initial begin
    int c0, d0, cs0, len;
    logic m;
    logic [AW-1:0] s, d;
    logic [DW-1:0] f;

    for (int i = 0; i < 3; i++) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < N; i++) preload(AW'(i), $urandom);
    mem_cmp("preload");

    run("fill_basic", 1'b1, 10'h000, 10'h010, 4, 32'hA5A5_0001);
    chk("fill_basic_ck_const", 64'(checksum), 64'h0);

    preload(10'h100, 32'h11); preload(10'h101, 32'h22); preload(10'h102, 32'h44);
    run("copy_basic", 1'b0, 10'h100, 10'h200, 3, 32'h0);
    chk("copy_basic_ck_const", 64'(checksum), 64'h77);

    run("fill_wrap", 1'b1, 10'h000, 10'h3FE, 4, 32'hDEAD_BEEF);

    cs0 = cs_cnt;
    run("copy_len0", 1'b0, 10'h050, 10'h060, 0, 32'h0);
    chk("copy_len0_no_cs", 64'(cs_cnt - cs0), 64'd0);

    // Abort during WAIT of word 1: only word 0 lands.
    d0 = done_cnt;
    issue("abort", 1'b0, 10'h080, 10'h300, 5, 32'h0, c0);
    repeat (4) tick();
    chk("abort_in_wait_cs", 64'(avm_chipselect), 64'd0);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    model(1'b0, 10'h080, 10'h300, 1, 32'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_checksum", 64'(checksum), 64'(ref_ck));
    repeat (5) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    mem_cmp("abort");
    run("after_abort", 1'b0, 10'h2F0, 10'h310, 6, 32'h0);

    // Reset during FILL of word 2 of 8: words 0..2 land, nothing after.
    d0 = done_cnt;
    issue("rst_mid", 1'b1, 10'h000, 10'h140, 8, 32'hCAFE_F00D, c0);
    repeat (2) tick();
    chk("rst_mid_in_fill", 64'(avm_address), 64'h142);
    reset = 1'b1;
    tick();
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    model(1'b1, 10'h000, 10'h140, 3, 32'hCAFE_F00D);
    repeat (3) tick();
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    mem_cmp("rst_mid");

    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom_range(0, 1));
      s = AW'($urandom); d = AW'($urandom); f = $urandom;
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = N;
        default: len = $urandom_range(1, 40);
      endcase
      run($sformatf("rand%0d", t), m, s, d, len, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
